// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared defaults and the fetch-control state type used by the
//               fetch/redirect block and the IF/ID register.
//               Contents:
//                 XLEN     - default datapath / PC width
//                 NOP_INST - addi x0,x0,0, injected into IF/ID on a flush
//                 RESET_PC - default PC after reset
//                 fetch_state_e - BOOT / RUN fetch-control states
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with hold and flush controls.
//               Flush has priority over hold: a squashed instruction must not
//               be kept alive by a stall raised on its behalf.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_hold          - keep current contents
//               i_flush         - load {0, NOP, valid=0}
//               i_pc, i_inst    - PC and instruction being fetched
//               o_pc, o_inst    - registered PC / instruction
//               o_valid         - 1 = real instruction, 0 = bubble
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg import pipeline_pkg::*; #(
  parameter int          XLEN = pipeline_pkg::XLEN,
  parameter logic [31:0] NOP  = pipeline_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_hold,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_inst,
  output logic [XLEN-1:0] o_pc,
  output logic [31:0]     o_inst,
  output logic            o_valid
);

  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_inst;
  logic            r_valid;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_pc    <= '0;
      r_inst  <= NOP;
      r_valid <= 1'b0;
    end else if (!i_hold) begin
      r_pc    <= i_pc;
      r_inst  <= i_inst;
      r_valid <= 1'b1;
    end
  end

  assign o_pc    = r_pc;
  assign o_inst  = r_inst;
  assign o_valid = r_valid;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/pipeline_fetch_redirect.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_fetch_redirect
// Description : Fetch stage consumer of the MEM-stage branch decision. Owns
//               the PC and the IF/ID register, applies redirects, issues the
//               downstream flushes, honours the load-use stall and keeps
//               redirect / bubble statistics.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_pc_src          - redirect request from MEM
//               i_branch_target   - redirect target (valid with i_pc_src)
//               i_stall           - load-use stall from ID
//               i_inst_in         - imem read data for o_pc_out
//               o_pc_out          - current PC / imem address
//               o_ifid_pc/inst/valid - IF/ID contents
//               o_flush_id_ex, o_flush_ex_mem - same-edge downstream clears
//               o_misalign        - sticky misaligned-target flag
//               o_redirect_cnt    - accepted redirects (wraps)
//               o_bubble_cnt      - RUN cycles with an IF/ID bubble (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_fetch_redirect import pipeline_pkg::*; #(
  parameter int              XLEN     = pipeline_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(pipeline_pkg::RESET_PC),
  parameter logic [31:0]     NOP      = pipeline_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_pc_src,
  input  logic [XLEN-1:0] i_branch_target,
  input  logic            i_stall,
  input  logic [31:0]     i_inst_in,
  output logic [XLEN-1:0] o_pc_out,
  output logic [XLEN-1:0] o_ifid_pc,
  output logic [31:0]     o_ifid_inst,
  output logic            o_ifid_valid,
  output logic            o_flush_id_ex,
  output logic            o_flush_ex_mem,
  output logic            o_misalign,
  output logic [31:0]     o_redirect_cnt,
  output logic [31:0]     o_bubble_cnt
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic            w_in_run;
  logic            w_redirect;
  logic            w_hold;

  logic [XLEN-1:0] r_pc;
  logic            r_misalign;
  logic [31:0]     r_redirect_cnt;
  logic [31:0]     r_bubble_cnt;

  // --------------------------------------------------------------------------
  // Fetch-control FSM. BOOT is a single cycle in which fetch runs freely and
  // redirect/stall requests are ignored, since nothing is in flight yet.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_run    = 1'b0;
    w_redirect  = 1'b0;
    w_hold      = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
        w_in_run    = 1'b1;
        w_redirect  = i_pc_src;
        // A redirect squashes the stalling instruction, so it wins.
        w_hold      = i_stall & ~i_pc_src;
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // PC register. Low two target bits are dropped on load; PC+4 wraps.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_pc <= {i_branch_target[XLEN-1:2], 2'b00};
    end else if (!w_hold) begin
      r_pc <= r_pc + XLEN'(4);
    end
  end

  // --------------------------------------------------------------------------
  // Debug statistics. Bubble counting looks at IF/ID validity before the
  // edge, so stalled bubble cycles are counted too.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign     <= 1'b0;
      r_redirect_cnt <= '0;
      r_bubble_cnt   <= '0;
    end else begin
      if (w_redirect) begin
        r_redirect_cnt <= r_redirect_cnt + 32'd1;
        if (i_branch_target[1:0] != 2'b00) begin
          r_misalign <= 1'b1;
        end
      end
      if (w_in_run && !o_ifid_valid) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
    end
  end

  if_id_reg #(
    .XLEN (XLEN),
    .NOP  (NOP)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .i_hold  (w_hold),
    .i_flush (w_redirect),
    .i_pc    (r_pc),
    .i_inst  (i_inst_in),
    .o_pc    (o_ifid_pc),
    .o_inst  (o_ifid_inst),
    .o_valid (o_ifid_valid)
  );

  // Flushes follow pc_src directly so ID/EX and EX/MEM clear on the same
  // edge that loads the target into the PC.
  assign o_flush_id_ex  = i_pc_src;
  assign o_flush_ex_mem = i_pc_src;

  assign o_pc_out       = r_pc;
  assign o_misalign     = r_misalign;
  assign o_redirect_cnt = r_redirect_cnt;
  assign o_bubble_cnt   = r_bubble_cnt;

endmodule : pipeline_fetch_redirect
`default_nettype wire

// File: tb/tb_pipeline_fetch_redirect.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_fetch_redirect
// Description : Self-checking bench for pipeline_fetch_redirect. A cycle-level
//               reference model tracks PC, IF/ID and statistics; a compare
//               process checks every output each cycle, and directed
//               sequences pin key values with literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_fetch_redirect;

  localparam logic [31:0] NOP_C = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_src = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic [31:0] inst_in;
  logic        use_fixed = 1'b1;
  logic [31:0] fixed_inst = 32'h0010_0093;

  logic [31:0] pc_out, ifid_pc, ifid_inst, redirect_cnt, bubble_cnt;
  logic        ifid_valid, flush_id_ex, flush_ex_mem, misalign;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // reference model state
  logic [31:0] m_pc, m_ifpc, m_inst, m_rc, m_bc;
  logic        m_valid, m_mis, m_boot;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign inst_in = use_fixed ? fixed_inst : imem(pc_out);

  pipeline_fetch_redirect dut (
    .clk             (clk),
    .rst             (rst),
    .i_pc_src        (pc_src),
    .i_branch_target (tgt),
    .i_stall         (stall),
    .i_inst_in       (inst_in),
    .o_pc_out        (pc_out),
    .o_ifid_pc       (ifid_pc),
    .o_ifid_inst     (ifid_inst),
    .o_ifid_valid    (ifid_valid),
    .o_flush_id_ex   (flush_id_ex),
    .o_flush_ex_mem  (flush_ex_mem),
    .o_misalign      (misalign),
    .o_redirect_cnt  (redirect_cnt),
    .o_bubble_cnt    (bubble_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the architectural effect of one clock edge.
  always @(posedge clk) begin : model
    logic [31:0] cur;
    cur = use_fixed ? fixed_inst : imem(m_pc);
    if (rst) begin
      m_pc = 32'h0; m_ifpc = 32'h0; m_inst = NOP_C; m_valid = 1'b0;
      m_mis = 1'b0; m_rc = 32'h0; m_bc = 32'h0; m_boot = 1'b1;
    end else if (m_boot) begin
      m_ifpc = m_pc; m_inst = cur; m_valid = 1'b1;
      m_pc = m_pc + 32'd4; m_boot = 1'b0;
    end else begin
      if (!m_valid) m_bc = m_bc + 32'd1;
      if (pc_src) begin
        m_rc = m_rc + 32'd1;
        if (tgt % 4 != 0) m_mis = 1'b1;
        m_pc = tgt - (tgt % 4);
        m_ifpc = 32'h0; m_inst = NOP_C; m_valid = 1'b0;
      end else if (!stall) begin
        m_ifpc = m_pc; m_inst = cur; m_valid = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // Compare process: every cycle once the model has seen a reset edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc_out",       pc_out,       m_pc);
      chk("ifid_pc",      ifid_pc,      m_ifpc);
      chk("ifid_inst",    ifid_inst,    m_inst);
      chk("ifid_valid",   {31'b0, ifid_valid},   {31'b0, m_valid});
      chk("misalign",     {31'b0, misalign},     {31'b0, m_mis});
      chk("redirect_cnt", redirect_cnt, m_rc);
      chk("bubble_cnt",   bubble_cnt,   m_bc);
      chk("flush_id_ex",  {31'b0, flush_id_ex},  {31'b0, pc_src});
      chk("flush_ex_mem", {31'b0, flush_ex_mem}, {31'b0, pc_src});
    end
  end

  task automatic drive(input logic r, input logic p, input logic [31:0] t, input logic s);
    rst = r; pc_src = p; tgt = t; stall = s;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] bc_save;
    logic        r, p, s;
    logic [31:0] t;

    // Reset held two cycles
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    chk_en = 1'b1;
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
    chk("rst_inst", ifid_inst, NOP_C);
    chk("rst_rc", redirect_cnt, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("boot_pc", pc_out, 32'h0);
    chk("boot_valid", {31'b0, ifid_valid}, 32'h0);
    tick();
    chk("run_pc4", pc_out, 32'h4);
    chk("run_valid", {31'b0, ifid_valid}, 32'h1);
    chk("run_ifpc", ifid_pc, 32'h0);
    chk("run_inst", ifid_inst, 32'h0010_0093);
    tick();
    chk("run_pc8", pc_out, 32'h8);
    tick(); tick();
    chk("pc_10", pc_out, 32'h10);

    // Redirect at PC=0x10
    drive(1'b0, 1'b1, 32'h40, 1'b0);
    chk("flush_idex_lit", {31'b0, flush_id_ex}, 32'h1);
    chk("flush_exmem_lit", {31'b0, flush_ex_mem}, 32'h1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("redir_pc", pc_out, 32'h40);
    chk("redir_valid", {31'b0, ifid_valid}, 32'h0);
    chk("redir_inst", ifid_inst, NOP_C);
    chk("redir_cnt", redirect_cnt, 32'h1);
    tick();
    chk("tgt_valid", {31'b0, ifid_valid}, 32'h1);
    chk("tgt_ifpc", ifid_pc, 32'h40);

    // Redirect with simultaneous stall
    drive(1'b0, 1'b1, 32'h80, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("rs_pc", pc_out, 32'h80);
    chk("rs_valid", {31'b0, ifid_valid}, 32'h0);
    chk("rs_cnt", redirect_cnt, 32'h2);

    // Stall 3 cycles at PC=0x20
    drive(1'b0, 1'b1, 32'h1C, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk("st_pc0", pc_out, 32'h20);
    bc_save = m_bc;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("st_pc", pc_out, 32'h20);
      chk("st_ifpc", ifid_pc, 32'h1C);
      chk("st_bc", bubble_cnt, bc_save);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk("st_resume", pc_out, 32'h24);

    // Misaligned target, sticky flag
    drive(1'b0, 1'b1, 32'h46, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("mis_pc", pc_out, 32'h44);
    chk("mis_flag", {31'b0, misalign}, 32'h1);
    tick(); tick();
    chk("mis_sticky", {31'b0, misalign}, 32'h1);

    // PC wrap
    drive(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk("wrap_fffc", pc_out, 32'hFFFF_FFFC);
    tick();
    chk("wrap_0", pc_out, 32'h0);

    // Reset during redirect
    drive(1'b1, 1'b1, 32'h100, 1'b0);
    tick();
    chk("rr_pc", pc_out, 32'h0);
    chk("rr_cnt", redirect_cnt, 32'h0);
    chk("rr_mis", {31'b0, misalign}, 32'h0);

    // Back-to-back redirects after boot
    drive(1'b0, 1'b1, 32'h500, 1'b0);
    tick();
    chk("boot_ign_pc", pc_out, 32'h4);
    chk("boot_ign_cnt", redirect_cnt, 32'h0);
    drive(1'b0, 1'b1, 32'h200, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h300, 1'b0);
    chk("b2b_pc1", pc_out, 32'h200);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("b2b_pc2", pc_out, 32'h300);
    chk("b2b_cnt", redirect_cnt, 32'h2);

    // Randomized phase against the model
    use_fixed = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      p = ($urandom_range(0, 7) == 0);
      s = m_boot ? 1'b0 : ($urandom_range(0, 3) == 0);
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      drive(r, p, t, s);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pipeline_fetch_redirect
`default_nettype wire

// File: doc/pipeline_fetch_redirect.md
# pipeline_fetch_redirect

Fetch-side consumer of the MEM-stage branch decision: it owns the PC register and the IF/ID pipeline register, and applies `pc_src` and the branch target when they arrive from MEM. On a redirect it loads the target into the PC. In the same cycle it drives the flush controls that squash the three younger in-flight instructions (IF/ID, ID/EX, EX/MEM). It also honours the load-use stall from ID and keeps redirect/bubble statistics for lab debug.

## Interface
- `XLEN`, 32, datapath/PC width
- `RESET_PC`, 32'h0000_0000, PC value after reset
- `NOP`, 32'h0000_0013, instruction injected into IF/ID on flush (addi x0,x0,0)

- `clk` input 1: single clock; all state updates on rising edge
- `rst` input 1: synchronous, active-high reset
- `pc_src` input 1: redirect request from MEM stage, (Branch&zero)|(BranchN&~zero)|Jump
- `branch_target` input XLEN: target PC from EX/MEM; valid when `pc_src`=1
- `stall` input 1: load-use hazard from ID; hold PC and IF/ID
- `inst_in` input 32: instruction-memory read data for address `pc_out` (combinational read)
- `pc_out` output XLEN: current PC, drives instruction-memory address
- `ifid_pc` output XLEN: PC of instruction in IF/ID
- `ifid_inst` output 32: instruction in IF/ID
- `ifid_valid` output 1: IF/ID holds a real instruction (0 = bubble)
- `flush_id_ex` output 1: clear ID/EX at next edge
- `flush_ex_mem` output 1: clear EX/MEM at next edge
- `misalign` output 1: sticky; set when a redirect target has `[1:0]`≠0
- `redirect_cnt` output 32: count of accepted redirects, wraps
- `bubble_cnt` output 32: count of cycles `ifid_valid`=0 after leaving BOOT, wraps

## Operation
- FSM states: BOOT, RUN.
  - BOOT is entered on `rst`. It lasts one cycle; IF/ID stays invalid. Next state is RUN.
  - RUN stays in RUN until `rst`.
- Per-edge priority in RUN: `rst` > `pc_src` > `stall` > normal.
- Normal:
  - PC ← PC+4.
  - IF/ID ← {PC, `inst_in`, valid=1}.
- Stall (`stall`=1, `pc_src`=0): PC, IF/ID and all flags hold.
- Redirect (`pc_src`=1):
  - PC ← {`branch_target`[XLEN-1:2], 2'b00}.
  - IF/ID ← {0, `NOP`, valid=0}.
  - `redirect_cnt`+1.
  - If `branch_target`[1:0]≠0, `misalign`←1.
  - Redirect overrides a simultaneous `stall`, because the stalling instruction is itself squashed.
- `flush_id_ex` = `flush_ex_mem` = `pc_src`, combinational, so the downstream registers clear on the same edge the PC loads.
- In BOOT, PC+4 fetch proceeds normally, and `pc_src` is ignored (the pipeline is empty).
- Arithmetic: PC+4 is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0. Counters wrap modulo 2^32.
- `bubble_cnt` increments in RUN on every edge at which `ifid_valid` is 0 before the update, including cycles that are stalled.

## Timing
- Reset values, applied at the first edge with `rst`=1:
  - `pc_out`=`RESET_PC`
  - `ifid_pc`=0, `ifid_inst`=`NOP`, `ifid_valid`=0
  - `misalign`=0, both counters 0, state BOOT
- The flush outputs depend only on `pc_src`.
- Reset held mid-redirect: reset wins and no counter updates.
- Redirect latency: with `pc_src` high in cycle N, `pc_out`=target in N+1. The target instruction is valid in IF/ID in N+2.
- Branch penalty is 3 squashed slots, all produced by this block plus the two flush outputs.
- Back-to-back `pc_src` in consecutive cycles: each is applied and each is counted. Under correct MEM behaviour the second cannot occur, but the block must not mask it.
- Stall held k cycles: `pc_out` and IF/ID are unchanged for k edges, and `bubble_cnt` is unchanged while `ifid_valid`=1.

## Structure
- Shared package `pipeline_pkg` holds:
  - `XLEN`, `NOP_INST`, `RESET_PC` defaults
  - the FSM state enum (`ST_BOOT`, `ST_RUN`)
- One sub-module, `if_id_reg`: the IF/ID register with hold (stall) and flush inputs, reused by the ID stage. The PC, FSM and counters stay in the top module.

## Test plan
- Reset: hold `rst` 2 cycles, release with `inst_in`=32'h0010_0093 → `pc_out` goes 0,4,8; `ifid_valid` is 0 in the BOOT cycle, then 1 with `ifid_pc`=0.
- Redirect: `pc_src`=1, `branch_target`=32'h0000_0040 at PC=0x10 → same-cycle `flush_id_ex`=`flush_ex_mem`=1; next `pc_out`=0x40, IF/ID=`NOP`/invalid; `redirect_cnt`=1; IF/ID valid with `ifid_pc`=0x40 one cycle later.
- Redirect + stall in the same cycle: `pc_src`=1, `stall`=1, target 0x80 → `pc_out`=0x80 and IF/ID flushed (stall ignored).
- Stall 3 cycles at PC=0x20 → `pc_out` stays 0x20, IF/ID unchanged, `bubble_cnt` unchanged; PC resumes at 0x24 after release.
- Misaligned target 32'h0000_0046 → `pc_out`=0x44, `misalign`=1 and sticky until `rst`.
- Wrap: with PC=32'hFFFF_FFFC and no redirect → next `pc_out`=0. Reset asserted while `pc_src`=1 → `pc_out`=`RESET_PC` and `redirect_cnt`=0.
